nibble_word_packer: RTL and testbench

- Narrow-to-wide gearbox. Accepts a stream of PORTB_DW-bit symbols on a valid/ready handshake and packs them into PORTA_DW-bit words.
- Emits each word with an auto-incrementing word address, ready to drive the wide write port of the asymmetric dual-port RAM.
- It is the writer-side counterpart to the wide-write / narrow-read path: narrow data in, wide words out.
- Lane mapping matches the RAM's asymmetric addressing. Narrow symbol k lands in word k/RATIO, lane k%RATIO, at bits [PORTB_DW*(k%RATIO) +: PORTB_DW]. Lane 0 is the LSB.

---
 rtl/nibble_word_packer.sv | 97 +++++++++
 tb/tb_nibble_word_packer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_word_packer.sv
// Narrow-to-wide gearbox: packs PORTB_DW-bit symbols into PORTA_DW-bit words,
// lane 0 in the LSBs, each word tagged with an auto-incrementing word address.
module nibble_word_packer #(
    parameter  int PORTB_DW = 4,
    parameter  int PORTA_DW = 16,
    parameter  int PORTA_AW = 8,
    localparam int RATIO    = PORTA_DW / PORTB_DW,
    localparam int LW       = $clog2(RATIO) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [PORTB_DW-1:0] s_data,
    input  logic                s_last,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [PORTA_DW-1:0] m_data,
    output logic [PORTA_AW-1:0] m_addr,
    output logic [RATIO-1:0]    m_keep,
    output logic [LW-1:0]       lane_cnt
);

    localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

    logic [PORTA_DW-1:0] r_acc;
    logic [LW-1:0]       r_lane;
    logic [PORTA_AW-1:0] r_wcnt;
    logic                r_mvalid;
    logic [PORTA_DW-1:0] r_mdata;
    logic [PORTA_AW-1:0] r_maddr;
    logic [RATIO-1:0]    r_mkeep;

    logic                w_beat;
    logic                w_close;
    logic [PORTA_DW-1:0] w_merged;
    logic [RATIO-1:0]    w_keep;

    assign s_ready  = !r_mvalid || m_ready;
    assign w_beat   = s_valid && s_ready;
    assign w_close  = w_beat && ((r_lane == LAST_LANE) || s_last);

    assign m_valid  = r_mvalid;
    assign m_data   = r_mdata;
    assign m_addr   = r_maddr;
    assign m_keep   = r_mkeep;
    assign lane_cnt = r_lane;

    // Accumulator with the incoming symbol merged into the current lane, and
    // the thermometer mask of lanes filled once this beat lands.
    always_comb begin
        w_merged = r_acc;
        w_keep   = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (r_lane == LW'(i)) begin
                w_merged[i*PORTB_DW +: PORTB_DW] = s_data;
            end
            w_keep[i] = (LW'(i) <= r_lane);
        end
    end

    // clr outranks every handshake, so a beat in the clr cycle is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_lane   <= '0;
            r_wcnt   <= '0;
            r_mvalid <= 1'b0;
            r_mdata  <= '0;
            r_maddr  <= '0;
            r_mkeep  <= '0;
        end else if (clr) begin
            r_acc    <= '0;
            r_lane   <= '0;
            r_wcnt   <= '0;
            r_mvalid <= 1'b0;
        end else begin
            if (r_mvalid && m_ready) begin
                r_mvalid <= 1'b0;
            end
            if (w_close) begin
                r_mdata  <= w_merged;
                r_mkeep  <= w_keep;
                r_maddr  <= r_wcnt;
                r_mvalid <= 1'b1;
                r_wcnt   <= r_wcnt + PORTA_AW'(1);
                r_lane   <= '0;
                r_acc    <= '0;
            end else if (w_beat) begin
                r_acc    <= w_merged;
                r_lane   <= r_lane + LW'(1);
            end
        end
    end

endmodule

// File: tb/tb_nibble_word_packer.sv
// Scoreboard bench for nibble_word_packer: a reference packer model queues the
// expected words as symbols are accepted; a monitor compares retiring words.
module tb_nibble_word_packer;

    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  addr;
        logic [3:0]  keep;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        sValid = 1'b0;
    logic        sReady;
    logic [3:0]  sData = '0;
    logic        sLast = 1'b0;
    logic        mValid;
    logic        mReady = 1'b1;
    logic [15:0] mData;
    logic [7:0]  mAddr;
    logic [3:0]  mKeep;
    logic [2:0]  laneCnt;

    logic        bSValid = 1'b0;
    logic        bSReady;
    logic [3:0]  bSData = '0;
    logic        bMValid;
    logic [15:0] bMData;
    logic [1:0]  bMAddr;
    logic [3:0]  bMKeep;
    logic [2:0]  bLaneCnt;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    word_t       expQ[$];
    int          retCyc[$];
    int          mLane = 0;
    logic [15:0] mAcc = '0;
    logic [7:0]  mAddrCnt = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_word_packer dut (
        .clk(clk), .rst(rst), .clr(clr),
        .s_valid(sValid), .s_ready(sReady), .s_data(sData), .s_last(sLast),
        .m_valid(mValid), .m_ready(mReady), .m_data(mData), .m_addr(mAddr),
        .m_keep(mKeep), .lane_cnt(laneCnt)
    );

    nibble_word_packer #(.PORTA_AW(2)) dutWrap (
        .clk(clk), .rst(rst), .clr(1'b0),
        .s_valid(bSValid), .s_ready(bSReady), .s_data(bSData), .s_last(1'b0),
        .m_valid(bMValid), .m_ready(1'b1), .m_data(bMData), .m_addr(bMAddr),
        .m_keep(bMKeep), .lane_cnt(bLaneCnt)
    );

    // Compare each retiring word against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && !clr && mValid && mReady) begin
            retCyc.push_back(cyc);
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_word: got data=%h addr=%0d, none expected", mData, mAddr);
            end else begin
                word_t e;
                e = expQ.pop_front();
                if ({mData, mAddr, mKeep} !== {e.data, e.addr, e.keep}) begin
                    failures++;
                    $display("[TB] FAIL word: got data=%h addr=%0d keep=%h, expected data=%h addr=%0d keep=%h",
                             mData, mAddr, mKeep, e.data, e.addr, e.keep);
                end
            end
        end
    end

    function automatic void modelReset();
        expQ.delete();
        mLane    = 0;
        mAcc     = '0;
        mAddrCnt = '0;
    endfunction

    function automatic void modelBeat(input logic [3:0] d, input logic last);
        word_t w;
        mAcc[mLane*4 +: 4] = d;
        if (mLane == 3 || last) begin
            w.data = mAcc;
            w.addr = mAddrCnt;
            w.keep = 4'((1 << (mLane + 1)) - 1);
            expQ.push_back(w);
            mAddrCnt = mAddrCnt + 8'd1;
            mLane    = 0;
            mAcc     = '0;
        end else begin
            mLane++;
        end
    endfunction

    // Entered and left at #1 after a rising edge; holds the symbol until accepted.
    task automatic applyStimulus(input logic [3:0] d, input logic last, output int stalls);
        stalls = 0;
        sValid = 1'b1;
        sData  = d;
        sLast  = last;
        @(negedge clk);
        while (!sReady && stalls < 50) begin
            @(negedge clk);
            stalls++;
        end
        checks++;
        if (!sReady) begin
            failures++;
            $display("[TB] FAIL accept_timeout: s_ready=%b, expected 1 within 50 cycles", sReady);
        end else begin
            modelBeat(d, last);
        end
        @(posedge clk);
        #1;
        sValid = 1'b0;
        sLast  = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s_drain: %0d words outstanding, expected 0", name, expQ.size());
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        clr = 1'b0;
        sValid = 1'b0;
        sLast = 1'b0;
        bSValid = 1'b0;
        mReady = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if ({mValid, mData, mKeep, mAddr, laneCnt, sReady} !== {1'b0, 16'h0, 4'h0, 8'h0, 3'h0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL reset_state: got valid=%b data=%h keep=%h addr=%0d lane=%0d ready=%b, expected 0,0000,0,0,0,1",
                     mValid, mData, mKeep, mAddr, laneCnt, sReady);
        end
    endtask

    task automatic test_full_words();
        int st;
        doReset();
        applyStimulus(4'h1, 1'b0, st);
        applyStimulus(4'h2, 1'b0, st);
        checks++;
        if (laneCnt !== 3'd2) begin
            failures++;
            $display("[TB] FAIL lane_cnt_partial: got %0d, expected 2", laneCnt);
        end
        applyStimulus(4'h3, 1'b0, st);
        applyStimulus(4'h4, 1'b0, st);
        checks++;
        if (mValid !== 1'b1 || mData !== 16'h4321 || laneCnt !== 3'd0) begin
            failures++;
            $display("[TB] FAIL first_word_latency: got valid=%b data=%h lane=%0d, expected 1,4321,0", mValid, mData, laneCnt);
        end
        for (int i = 5; i <= 8; i++) applyStimulus(4'(i), 1'b0, st);
        waitDrain("full_words");
    endtask

    task automatic test_flush();
        int st;
        doReset();
        applyStimulus(4'hA, 1'b0, st);
        applyStimulus(4'hB, 1'b1, st);
        checks++;
        if (mKeep !== 4'h3 || mData !== 16'h00BA) begin
            failures++;
            $display("[TB] FAIL flush_partial: got data=%h keep=%h, expected 00ba,3", mData, mKeep);
        end
        applyStimulus(4'hC, 1'b1, st);
        checks++;
        if (mKeep !== 4'h1 || mAddr !== 8'd1) begin
            failures++;
            $display("[TB] FAIL flush_single: got keep=%h addr=%0d, expected 1,1", mKeep, mAddr);
        end
        waitDrain("flush");
    endtask

    task automatic test_backpressure();
        int st;
        doReset();
        mReady = 1'b0;
        for (int i = 1; i <= 4; i++) applyStimulus(4'(i), 1'b0, st);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (sReady !== 1'b0 || mValid !== 1'b1 || mData !== 16'h4321 || mAddr !== 8'd0 || mKeep !== 4'hF) begin
                failures++;
                $display("[TB] FAIL backpressure_hold: got ready=%b valid=%b data=%h addr=%0d keep=%h, expected 0,1,4321,0,f",
                         sReady, mValid, mData, mAddr, mKeep);
            end
        end
        @(posedge clk);
        #1;
        mReady = 1'b1;
        #1;
        checks++;
        if (sReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL backpressure_release: got s_ready=%b, expected 1", sReady);
        end
        waitDrain("backpressure");
        checks++;
        if (mValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL backpressure_retire: got m_valid=%b, expected 0", mValid);
        end
    endtask

    task automatic test_back_to_back();
        int st;
        int totalStalls = 0;
        int cStart;
        doReset();
        retCyc.delete();
        cStart = cyc;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(4'(i ^ 5), 1'b0, st);
            totalStalls += st;
        end
        waitDrain("stream");
        checks++;
        if (totalStalls != 0 || retCyc.size() != 4) begin
            failures++;
            $display("[TB] FAIL stream_rate: got stalls=%0d words=%0d, expected 0,4", totalStalls, retCyc.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (retCyc[k] - cStart != 4 * (k + 1)) begin
                    failures++;
                    $display("[TB] FAIL stream_offset%0d: got %0d, expected %0d", k, retCyc[k] - cStart, 4 * (k + 1));
                end
            end
        end
    endtask

    task automatic test_clr();
        int st;
        doReset();
        for (int i = 1; i <= 4; i++) applyStimulus(4'(i), 1'b0, st);
        waitDrain("clr_pre");
        applyStimulus(4'h1, 1'b0, st);
        applyStimulus(4'h2, 1'b0, st);
        clr = 1'b1;
        sValid = 1'b1;
        sData = 4'hF;
        @(posedge clk);
        #1;
        clr = 1'b0;
        sValid = 1'b0;
        modelReset();
        checks++;
        if (laneCnt !== 3'd0 || mValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clr_state: got lane=%0d valid=%b, expected 0,0", laneCnt, mValid);
        end
        for (int i = 5; i <= 8; i++) applyStimulus(4'(i), 1'b0, st);
        waitDrain("clr_post");
    endtask

    task automatic test_rst_mid_word();
        int st;
        doReset();
        for (int i = 1; i <= 4; i++) applyStimulus(4'(i), 1'b0, st);
        waitDrain("rst_pre");
        applyStimulus(4'h1, 1'b0, st);
        applyStimulus(4'h2, 1'b0, st);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (laneCnt !== 3'd0 || mValid !== 1'b0 || mAddr !== 8'd0) begin
            failures++;
            $display("[TB] FAIL async_rst: got lane=%0d valid=%b addr=%0d, expected 0,0,0", laneCnt, mValid, mAddr);
        end
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 9; i <= 12; i++) applyStimulus(4'(i), 1'b0, st);
        waitDrain("rst_post");
    endtask

    task automatic test_wrap();
        int words = 0;
        logic [1:0] expAddr = 2'd0;
        logic [15:0] expData;
        doReset();
        for (int c = 0; c < 24; c++) begin
            bSValid = (c < 20);
            bSData  = 4'(c);
            @(negedge clk);
            if (bMValid) begin
                for (int j = 0; j < 4; j++) expData[j*4 +: 4] = 4'(words * 4 + j);
                checks++;
                if (bMAddr !== expAddr || bMData !== expData) begin
                    failures++;
                    $display("[TB] FAIL wrap_word%0d: got addr=%0d data=%h, expected %0d,%h",
                             words, bMAddr, bMData, expAddr, expData);
                end
                expAddr = expAddr + 2'd1;
                words++;
            end
            @(posedge clk);
            #1;
        end
        bSValid = 1'b0;
        checks++;
        if (words != 5) begin
            failures++;
            $display("[TB] FAIL wrap_count: got %0d words, expected 5", words);
        end
    endtask

    initial begin
        test_reset();
        test_full_words();
        test_flush();
        test_backpressure();
        test_back_to_back();
        test_clr();
        test_rst_mid_word();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
